// File: rtl/logic_pipe_unit.sv
// logic_pipe_unit
// Two-stage pipelined bitwise logic unit. Each beat applies one of eight
// 2-input Boolean functions (selected by op) across WIDTH-bit operands a and b.
// Valid/ready handshake on both the input and output sides.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand beat offered
//   in_ready   unit accepts the beat this cycle (combinational from out_ready)
//   a, b       WIDTH-bit operands
//   op         function select, captured with the operands
//   out_valid  result beat available
//   out_ready  consumer accepts the result this cycle
//   y          WIDTH-bit result
//   y_zero     high when y == 0, qualified by out_valid
//   op_count   wrapping count of completed output transfers
//   y_parity   XOR-reduction of y (only when LOGIC_PIPE_PARITY_EN is defined)
//
// Optional feature macro: LOGIC_PIPE_PARITY_EN
module logic_pipe_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic [CNT_W-1:0] op_count
`ifdef LOGIC_PIPE_PARITY_EN
  ,
  output logic             y_parity
`endif
);

  // Stage 1: captured operands
  logic             s1_valid_reg;
  logic [WIDTH-1:0] a1_reg;
  logic [WIDTH-1:0] b1_reg;
  logic [2:0]       op1_reg;

  // Stage 2: registered result
  logic             s2_valid_reg;
  logic [WIDTH-1:0] y_reg;
  logic             y_zero_reg;
  logic [CNT_W-1:0] op_count_reg;

  logic             s1_en;
  logic             s2_en;
  logic             in_xfer;
  logic             out_xfer;
  logic [3:0]       lut;
  logic [WIDTH-1:0] f_next;

  assign s2_en    = ~s2_valid_reg | out_ready;
  assign s1_en    = ~s1_valid_reg | s2_en;
  assign in_ready = s1_en;
  assign in_xfer  = in_valid & s1_en;
  assign out_xfer = s2_valid_reg & out_ready;

  // Each function is expressed as a 4-entry truth table indexed by {a_bit, b_bit};
  // every result bit then reduces to a single table lookup.
  always_comb begin
    lut = 4'b0000;
    case (op1_reg)
      3'b000:  lut = 4'b1000; // AND
      3'b001:  lut = 4'b1110; // OR
      3'b010:  lut = 4'b0110; // XOR
      3'b011:  lut = 4'b0111; // NAND
      3'b100:  lut = 4'b0001; // NOR
      3'b101:  lut = 4'b1001; // XNOR
      3'b110:  lut = 4'b0100; // ANDN (a & ~b)
      default: lut = 4'b1010; // PASS_B
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign f_next[gi] = lut[{a1_reg[gi], b1_reg[gi]}];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      a1_reg       <= '0;
      b1_reg       <= '0;
      op1_reg      <= '0;
    end else if (s1_en) begin
      s1_valid_reg <= in_valid;
      // Operands only move on a real transfer so idle inputs never disturb stage 1.
      if (in_xfer) begin
        a1_reg  <= a;
        b1_reg  <= b;
        op1_reg <= op;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      y_reg        <= '0;
      y_zero_reg   <= 1'b0;
    end else if (s2_en) begin
      s2_valid_reg <= s1_valid_reg;
      // Bubbles leave y untouched so the last result stays visible.
      if (s1_valid_reg) begin
        y_reg      <= f_next;
        y_zero_reg <= (f_next == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_reg <= '0;
    end else if (out_xfer) begin
      op_count_reg <= op_count_reg + CNT_W'(1);
    end
  end

`ifdef LOGIC_PIPE_PARITY_EN
  logic y_parity_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_parity_reg <= 1'b0;
    end else if (s2_en && s1_valid_reg) begin
      y_parity_reg <= ^f_next;
    end
  end

  assign y_parity = y_parity_reg;
`endif

  assign out_valid = s2_valid_reg;
  assign y         = y_reg;
  assign y_zero    = y_zero_reg;
  assign op_count  = op_count_reg;

endmodule

// File: tb/tb_logic_pipe_unit.sv
// Directed testbench for logic_pipe_unit (WIDTH=8, CNT_W=4).
module tb_logic_pipe_unit;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [2:0]       op = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] y;
  logic             y_zero;
  logic [CNT_W-1:0] op_count;
`ifdef LOGIC_PIPE_PARITY_EN
  logic             y_parity;
`endif

  logic_pipe_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .y_zero    (y_zero),
    .op_count  (op_count)
`ifdef LOGIC_PIPE_PARITY_EN
    ,
    .y_parity  (y_parity)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int in_acc = 0;
  logic [7:0] rx_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Samples handshakes just before the edge, then advances to 1ns after it.
  task automatic step();
    #1;
    if (!rst && out_valid && out_ready) begin
      rx_q.push_back(y);
      $display("out transfer y=%h y_zero=%b", y, y_zero);
    end
    if (!rst && in_valid && in_ready) in_acc++;
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input logic [2:0] vop, input logic [7:0] exp_y, input logic exp_z);
    int n;
    a = va; b = vb; op = vop; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 6) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_y"}, 32'(y), 32'(exp_y));
    check({tag, "_zero"}, 32'(y_zero), 32'(exp_z));
  endtask

  logic [7:0] sweep_exp [8];
  logic [7:0] bp_exp [3];

  initial begin
    sweep_exp[0] = 8'h0A; sweep_exp[1] = 8'hAF; sweep_exp[2] = 8'hA5; sweep_exp[3] = 8'hF5;
    sweep_exp[4] = 8'h50; sweep_exp[5] = 8'h5A; sweep_exp[6] = 8'hA0; sweep_exp[7] = 8'h0F;
    bp_exp[0] = 8'h11; bp_exp[1] = 8'h22; bp_exp[2] = 8'h33;

    // Reset
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_y_zero", 32'(y_zero), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Single beat, latency
    a = 8'hF0; b = 8'h3C; op = 3'b010; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("lat_cycle1_valid", 32'(out_valid), 32'd0);
    step();
    check("lat_cycle2_valid", 32'(out_valid), 32'd1);
    check("lat_y", 32'(y), 32'hCC);
    check("lat_zero", 32'(y_zero), 32'd0);
    step();
    check("lat_count", 32'(op_count), 32'd1);
    check("lat_valid_drop", 32'(out_valid), 32'd0);

    // Op sweep, back-to-back
    rx_q.delete();
    a = 8'hAA; b = 8'h0F; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = 3'(i);
      step();
    end
    in_valid = 1'b0;
    step(); step();
    check("sweep_count_rx", 32'(rx_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < rx_q.size()) check($sformatf("sweep_op%0d", i), 32'(rx_q[i]), 32'(sweep_exp[i]));
    end
    check("sweep_op_count", 32'(op_count), 32'd9);

    // Backpressure: PASS_B so y equals b
    rx_q.delete();
    in_acc = 0;
    out_ready = 1'b0; op = 3'b111; a = 8'h00; in_valid = 1'b1;
    b = 8'h11; step();
    b = 8'h22; step();
    b = 8'h33;
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_y_head", 32'(y), 32'h11);
    step();
    check("bp_y_held", 32'(y), 32'h11);
    check("bp_accepted", 32'(in_acc), 32'd2);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    check("bp_rx_count", 32'(rx_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < rx_q.size()) check($sformatf("bp_order%0d", i), 32'(rx_q[i]), 32'(bp_exp[i]));
    end
    check("bp_op_count", 32'(op_count), 32'd12);

    // Zero flag and parity
    send_one("zero", 8'h55, 8'hAA, 3'b000, 8'h00, 1'b1);
    step();
    send_one("par", 8'h07, 8'h00, 3'b001, 8'h07, 1'b0);
`ifdef LOGIC_PIPE_PARITY_EN
    check("par_bit", 32'(y_parity), 32'd1);
`endif
    step();
    check("zp_op_count", 32'(op_count), 32'd14);

    // Reset mid-operation with both stages full
    out_ready = 1'b0; op = 3'b111; in_valid = 1'b1;
    b = 8'h77; step();
    b = 8'h88; step();
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_op_count", 32'(op_count), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    rx_q.delete();
    out_ready = 1'b1;
    step(); step(); step();
    check("mrst_no_ghost", 32'(rx_q.size()), 32'd0);

    // Counter wrap: 17 transfers with CNT_W=4
    rx_q.delete();
    a = 8'h00; op = 3'b111; in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      b = 8'(i);
      step();
    end
    in_valid = 1'b0;
    step(); step();
    check("wrap_rx_count", 32'(rx_q.size()), 32'd17);
    if (rx_q.size() == 17) check("wrap_last_y", 32'(rx_q[16]), 32'h10);
    check("wrap_op_count", 32'(op_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
